// File: rtl/bram_if_pkg.sv
// Shared constants and types for the BRAM-port address decoder.
// Field positions below refer to the word address (byte address >> 2).
package bram_if_pkg;

    localparam int unsigned ADDR_W    = 22;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned WADDR_W   = 20;
    localparam int unsigned TAG_W     = 3;
    localparam int unsigned BANK_W    = 5;
    localparam int unsigned IFMAP_AW  = 11;
    localparam int unsigned ROW_W     = 4;
    localparam int unsigned W_AW      = 6;
    localparam int unsigned CH_W      = 3;
    localparam int unsigned OBUF_AW   = 10;
    localparam int unsigned CSR_OFF_W = 17;
    localparam int unsigned ERR_CNT_W = 16;

    localparam int unsigned TAG_LSB  = 17;
    localparam int unsigned SEL_BIT  = 16;
    localparam int unsigned BANK_LSB = 11;
    localparam int unsigned ROW_LSB  = 6;
    localparam int unsigned CH_LSB   = 10;

    localparam logic [TAG_W-1:0] TAG_SA          = 3'd1;
    localparam logic [TAG_W-1:0] TAG_SA_DATA_BUF = 3'd2;
    localparam logic [TAG_W-1:0] TAG_CSR         = 3'd3;

    localparam logic [CSR_OFF_W-1:0] CSR_START  = 17'd0;
    localparam logic [CSR_OFF_W-1:0] CSR_DONE   = 17'd1;
    localparam logic [CSR_OFF_W-1:0] CSR_ERRCNT = 17'd2;

    typedef enum logic [2:0] {
        DEC_NONE,
        DEC_IFMAP,
        DEC_WEIGHT,
        DEC_OBUF,
        DEC_CSR,
        DEC_ERR
    } dec_target_e;

endpackage

// File: rtl/bram_if_decoder_if.sv
// 32-bit BRAM-controller port; the host drives it (master), the decoder responds (slave).
interface bram_if_decoder_if;
    import bram_if_pkg::*;

    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wrdata_a;
    logic [DATA_W-1:0] rddata_a;
    logic              en_a;
    logic [3:0]        we_a;

    modport master (output addr_a, wrdata_a, en_a, we_a, input rddata_a);
    modport slave  (input addr_a, wrdata_a, en_a, we_a, output rddata_a);
endinterface

// File: rtl/bram_addr_decode.sv
// Purely combinational word-address decode: target region, field extraction, range errors.
module bram_addr_decode
    import bram_if_pkg::*;
#(
    parameter int unsigned N_IFMAP_BANK = 25,
    parameter int unsigned N_W_ROW      = 6
) (
    input  logic [WADDR_W-1:0]   waddr_i,
    output dec_target_e          target_o,
    output logic [BANK_W-1:0]    bank_o,
    output logic [IFMAP_AW-1:0]  ifmap_addr_o,
    output logic [ROW_W-1:0]     row_o,
    output logic [W_AW-1:0]      w_addr_o,
    output logic [CH_W-1:0]      ch_o,
    output logic [OBUF_AW-1:0]   obuf_addr_o,
    output logic [CSR_OFF_W-1:0] csr_off_o
);

    assign bank_o       = waddr_i[BANK_LSB +: BANK_W];
    assign ifmap_addr_o = waddr_i[IFMAP_AW-1:0];
    assign row_o        = waddr_i[ROW_LSB +: ROW_W];
    assign w_addr_o     = waddr_i[W_AW-1:0];
    assign ch_o         = waddr_i[CH_LSB +: CH_W];
    assign obuf_addr_o  = waddr_i[OBUF_AW-1:0];
    assign csr_off_o    = waddr_i[CSR_OFF_W-1:0];

    // Output channels share the weight-row count, so ch is bounded by N_W_ROW too.
    always_comb begin
        target_o = DEC_ERR;
        case (waddr_i[TAG_LSB +: TAG_W])
            TAG_SA: begin
                if (waddr_i[SEL_BIT]) begin
                    target_o = (32'(row_o) < N_W_ROW) ? DEC_WEIGHT : DEC_ERR;
                end else begin
                    target_o = (32'(bank_o) < N_IFMAP_BANK) ? DEC_IFMAP : DEC_ERR;
                end
            end
            TAG_SA_DATA_BUF: target_o = (32'(ch_o) < N_W_ROW) ? DEC_OBUF : DEC_ERR;
            TAG_CSR:         target_o = (csr_off_o <= CSR_ERRCNT) ? DEC_CSR : DEC_ERR;
            default:         target_o = DEC_ERR;
        endcase
    end

endmodule

// File: rtl/bram_if_decoder.sv
// BRAM-port responder: routes host byte writes to ifmap/weight buffers, serves obuf/CSR reads.
// Build option: define BRAM_ERR_CNT_EN for a saturating decode-error counter at CSR2.
module bram_if_decoder
    import bram_if_pkg::*;
#(
    parameter int unsigned N_IFMAP_BANK = 25,
    parameter int unsigned N_W_ROW      = 6,
    parameter int unsigned DONE_W       = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    bram_if_decoder_if.slave    bus,
    output logic                ifmap_wr_en,
    output logic [BANK_W-1:0]   ifmap_wr_bank,
    output logic [IFMAP_AW-1:0] ifmap_wr_addr,
    output logic [7:0]          ifmap_wr_data,
    output logic                w_wr_en,
    output logic [ROW_W-1:0]    w_wr_row,
    output logic [W_AW-1:0]     w_wr_addr,
    output logic [7:0]          w_wr_data,
    output logic                obuf_rd_en,
    output logic [CH_W-1:0]     obuf_rd_ch,
    output logic [OBUF_AW-1:0]  obuf_rd_addr,
    input  logic [7:0]          obuf_rd_data,
    output logic                start_o,
    output logic [1:0]          nth_conv_o,
    input  logic [DONE_W-1:0]   done_i
);

    logic [WADDR_W-1:0]   waddr;
    dec_target_e          target;
    logic [BANK_W-1:0]    dec_bank;
    logic [IFMAP_AW-1:0]  dec_ifmap_addr;
    logic [ROW_W-1:0]     dec_row;
    logic [W_AW-1:0]      dec_w_addr;
    logic [CH_W-1:0]      dec_ch;
    logic [OBUF_AW-1:0]   dec_obuf_addr;
    logic [CSR_OFF_W-1:0] csr_off;

    logic wr, rd, acc_err, rd_err;
    logic wr_ifmap, wr_w, wr_csr0, rd_obuf, rd_csr;

    logic                ifmap_wr_en_q, w_wr_en_q, start_q, rd_obuf_q;
    logic [BANK_W-1:0]   ifmap_bank_q;
    logic [IFMAP_AW-1:0] ifmap_addr_q;
    logic [7:0]          ifmap_data_q;
    logic [ROW_W-1:0]    w_row_q;
    logic [W_AW-1:0]     w_addr_q;
    logic [7:0]          w_data_q;
    logic [1:0]          nth_conv_q;
    logic [DONE_W-1:0]   done_sticky_q, done_sticky_d;
    logic [DATA_W-1:0]   rddata_q, rddata_d, csr_rdata;

`ifdef BRAM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.addr_a[1:0], bus.wrdata_a[DATA_W-1:8], bus.we_a[3:1]};

    assign waddr = bus.addr_a[ADDR_W-1:2];
    assign wr    = bus.we_a[0];
    assign rd    = bus.en_a & ~bus.we_a[0];

    bram_addr_decode #(
        .N_IFMAP_BANK (N_IFMAP_BANK),
        .N_W_ROW      (N_W_ROW)
    ) u_dec (
        .waddr_i      (waddr),
        .target_o     (target),
        .bank_o       (dec_bank),
        .ifmap_addr_o (dec_ifmap_addr),
        .row_o        (dec_row),
        .w_addr_o     (dec_w_addr),
        .ch_o         (dec_ch),
        .obuf_addr_o  (dec_obuf_addr),
        .csr_off_o    (csr_off)
    );

    // Direction errors: the SA region is write-only, the output buffer read-only.
    always_comb begin
        acc_err = 1'b0;
        case (target)
            DEC_ERR:               acc_err = wr | rd;
            DEC_OBUF:              acc_err = wr;
            DEC_IFMAP, DEC_WEIGHT: acc_err = rd;
            default:               acc_err = 1'b0;
        endcase
    end

    assign rd_err   = rd & acc_err;
    assign wr_ifmap = wr & (target == DEC_IFMAP);
    assign wr_w     = wr & (target == DEC_WEIGHT);
    assign wr_csr0  = wr & (target == DEC_CSR) & (csr_off == CSR_START);
    assign rd_obuf  = rd & (target == DEC_OBUF);
    assign rd_csr   = rd & (target == DEC_CSR);

    assign obuf_rd_en   = rd_obuf;
    assign obuf_rd_ch   = rd_obuf ? dec_ch : '0;
    assign obuf_rd_addr = rd_obuf ? dec_obuf_addr : '0;

    always_comb begin
        csr_rdata = '0;
        case (csr_off)
            CSR_START: csr_rdata = DATA_W'({nth_conv_q, 1'b0});
            CSR_DONE:  csr_rdata = DATA_W'(done_sticky_q);
`ifdef BRAM_ERR_CNT_EN
            CSR_ERRCNT: csr_rdata = DATA_W'(err_cnt_q);
`endif
            default:   csr_rdata = '0;
        endcase
    end

    // A done pulse landing in the same cycle as start_o is lost: the clear takes priority.
    always_comb begin
        done_sticky_d = start_q ? '0 : (done_sticky_q | done_i);
        rddata_d      = rddata_q;
        if (rd_csr) begin
            rddata_d = csr_rdata;
        end else if (rd_err) begin
            rddata_d = '0;
        end else if (rd_obuf_q) begin
            rddata_d = DATA_W'(obuf_rd_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifmap_wr_en_q <= 1'b0;
            ifmap_bank_q  <= '0;
            ifmap_addr_q  <= '0;
            ifmap_data_q  <= '0;
            w_wr_en_q     <= 1'b0;
            w_row_q       <= '0;
            w_addr_q      <= '0;
            w_data_q      <= '0;
            start_q       <= 1'b0;
            nth_conv_q    <= '0;
            done_sticky_q <= '0;
            rd_obuf_q     <= 1'b0;
            rddata_q      <= '0;
        end else begin
            ifmap_wr_en_q <= wr_ifmap;
            if (wr_ifmap) begin
                ifmap_bank_q <= dec_bank;
                ifmap_addr_q <= dec_ifmap_addr;
                ifmap_data_q <= bus.wrdata_a[7:0];
            end
            w_wr_en_q <= wr_w;
            if (wr_w) begin
                w_row_q  <= dec_row;
                w_addr_q <= dec_w_addr;
                w_data_q <= bus.wrdata_a[7:0];
            end
            start_q <= wr_csr0 & bus.wrdata_a[0];
            if (wr_csr0) begin
                nth_conv_q <= bus.wrdata_a[2:1];
            end
            done_sticky_q <= done_sticky_d;
            rd_obuf_q     <= rd_obuf;
            rddata_q      <= rddata_d;
        end
    end

`ifdef BRAM_ERR_CNT_EN
    // Saturating error counter; any CSR2 write clears it.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (wr & (target == DEC_CSR) & (csr_off == CSR_ERRCNT)) begin
            err_cnt_d = '0;
        end else if (acc_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

    // Obuf data is only valid the cycle after the request, so it bypasses the capture register then.
    assign bus.rddata_a  = rd_obuf_q ? DATA_W'(obuf_rd_data) : rddata_q;
    assign ifmap_wr_en   = ifmap_wr_en_q;
    assign ifmap_wr_bank = ifmap_bank_q;
    assign ifmap_wr_addr = ifmap_addr_q;
    assign ifmap_wr_data = ifmap_data_q;
    assign w_wr_en       = w_wr_en_q;
    assign w_wr_row      = w_row_q;
    assign w_wr_addr     = w_addr_q;
    assign w_wr_data     = w_data_q;
    assign start_o       = start_q;
    assign nth_conv_o    = nth_conv_q;

endmodule

// File: tb/tb_bram_if_decoder.sv
// Directed bench for bram_if_decoder: vector table plus CSR, collision and reset sequences.
module tb_bram_if_decoder;
    import bram_if_pkg::*;

    localparam int unsigned DW = 17;
    localparam int CSR_W0 = (3 << 17);
    localparam int OBUF_5_195 = (2 << 17) + (5 << 10) + 195;

    logic clk = 1'b0;
    logic rst_n;
    bram_if_decoder_if bus();

    logic        ifmap_wr_en;
    logic [4:0]  ifmap_wr_bank;
    logic [10:0] ifmap_wr_addr;
    logic [7:0]  ifmap_wr_data;
    logic        w_wr_en;
    logic [3:0]  w_wr_row;
    logic [5:0]  w_wr_addr;
    logic [7:0]  w_wr_data;
    logic        obuf_rd_en;
    logic [2:0]  obuf_rd_ch;
    logic [9:0]  obuf_rd_addr;
    logic [7:0]  obuf_rd_data;
    logic        start_o;
    logic [1:0]  nth_conv_o;
    logic [DW-1:0] done_i;

    logic [7:0] obuf_mem [0:8191];

    int nvec = 0;
    int nerr = 0;
    int exp_errs = 0;

    always #5 clk = ~clk;

    bram_if_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .ifmap_wr_en   (ifmap_wr_en),
        .ifmap_wr_bank (ifmap_wr_bank),
        .ifmap_wr_addr (ifmap_wr_addr),
        .ifmap_wr_data (ifmap_wr_data),
        .w_wr_en       (w_wr_en),
        .w_wr_row      (w_wr_row),
        .w_wr_addr     (w_wr_addr),
        .w_wr_data     (w_wr_data),
        .obuf_rd_en    (obuf_rd_en),
        .obuf_rd_ch    (obuf_rd_ch),
        .obuf_rd_addr  (obuf_rd_addr),
        .obuf_rd_data  (obuf_rd_data),
        .start_o       (start_o),
        .nth_conv_o    (nth_conv_o),
        .done_i        (done_i)
    );

    // Output buffer model: data valid only in the cycle after a request.
    always @(posedge clk) begin
        if (obuf_rd_en) obuf_rd_data <= obuf_mem[{obuf_rd_ch, obuf_rd_addr}];
        else            obuf_rd_data <= 8'hEE;
    end

    typedef struct {
        int         w;
        logic [7:0] wd;
        logic [3:0] we;
        logic       en;
        logic       e_ifm, e_w, e_ren, e_err, chk_rd;
        int         e_sel, e_a, e_d;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(int w, logic [7:0] wd, logic [3:0] we, logic en,
                                logic ifm, logic wrw, logic ren, logic err, logic chk,
                                int sel, int a, int d, logic [31:0] rdv);
        vec_t v;
        v.w = w; v.wd = wd; v.we = we; v.en = en;
        v.e_ifm = ifm; v.e_w = wrw; v.e_ren = ren; v.e_err = err; v.chk_rd = chk;
        v.e_sel = sel; v.e_a = a; v.e_d = d; v.e_rd = rdv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic [7:0] d, input logic [3:0] we, input logic en);
        bus.addr_a   = 22'(w << 2);
        bus.wrdata_a = {24'h0, d};
        bus.we_a     = we;
        bus.en_a     = en;
    endtask

    task automatic idle();
        drive(0, 8'h00, 4'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ifmap_wr_en"}, 32'(ifmap_wr_en), 32'd0);
        chk({tag, " ifmap_fields"}, 32'({ifmap_wr_bank, ifmap_wr_addr, ifmap_wr_data}), 32'd0);
        chk({tag, " w_wr_en"}, 32'(w_wr_en), 32'd0);
        chk({tag, " w_fields"}, 32'({w_wr_row, w_wr_addr, w_wr_data}), 32'd0);
        chk({tag, " obuf_rd_en"}, 32'(obuf_rd_en), 32'd0);
        chk({tag, " start_o"}, 32'(start_o), 32'd0);
        chk({tag, " nth_conv_o"}, 32'(nth_conv_o), 32'd0);
        chk({tag, " rddata_a"}, bus.rddata_a, 32'd0);
    endtask

    vec_t vt [16];

    initial begin
        for (int i = 0; i < 8192; i++) obuf_mem[i] = 8'h00;
        obuf_mem[5*1024 + 195]  = 8'h19;
        obuf_mem[0]             = 8'h42;
        obuf_mem[4*1024 + 1023] = 8'hC3;

        vt[0]  = mk((1<<17)+(3<<11)+5,          8'h7F, 4'hF, 1'b0, 1,0,0,0,0, 3, 5, 8'h7F, 0);
        vt[1]  = mk((1<<17)+(1<<16)+(2<<6)+24,  8'h81, 4'hF, 1'b0, 0,1,0,0,0, 2, 24, 8'h81, 0);
        vt[2]  = mk((1<<17)+(1<<16)+(6<<6)+1,   8'h55, 4'hF, 1'b0, 0,0,0,1,0, 0, 0, 0, 0);
        vt[3]  = mk((1<<17)+(24<<11)+2047,      8'hA5, 4'h1, 1'b0, 1,0,0,0,0, 24, 2047, 8'hA5, 0);
        vt[4]  = mk((1<<17)+(25<<11),           8'h11, 4'hF, 1'b0, 0,0,0,1,0, 0, 0, 0, 0);
        vt[5]  = mk(5,                          8'h22, 4'hF, 1'b0, 0,0,0,1,0, 0, 0, 0, 0);
        vt[6]  = mk(5<<17,                      8'h33, 4'hF, 1'b0, 0,0,0,1,0, 0, 0, 0, 0);
        vt[7]  = mk((1<<17)+(4<<11)+9,          8'h44, 4'hE, 1'b0, 0,0,0,0,0, 0, 0, 0, 0);
        vt[8]  = mk((1<<17)+(1<<11)+7,          8'h3C, 4'h1, 1'b1, 1,0,0,0,0, 1, 7, 8'h3C, 0);
        vt[9]  = mk((1<<17)+(1<<16)+(5<<6)+63,  8'hFF, 4'hF, 1'b0, 0,1,0,0,0, 5, 63, 8'hFF, 0);
        vt[10] = mk(OBUF_5_195,                 8'h00, 4'h0, 1'b1, 0,0,1,0,1, 5, 195, 0, 32'h19);
        vt[11] = mk((2<<17),                    8'h00, 4'h0, 1'b1, 0,0,1,0,1, 0, 0, 0, 32'h42);
        vt[12] = mk((2<<17)+(6<<10)+3,          8'h00, 4'h0, 1'b1, 0,0,0,1,1, 0, 0, 0, 32'h0);
        vt[13] = mk((2<<17)+(4<<10)+1023,       8'h00, 4'h0, 1'b1, 0,0,1,0,1, 4, 1023, 0, 32'hC3);
        vt[14] = mk((1<<17)+5,                  8'h00, 4'h0, 1'b1, 0,0,0,1,1, 0, 0, 0, 32'h0);
        vt[15] = mk(CSR_W0+3,                   8'h00, 4'h0, 1'b1, 0,0,0,1,1, 0, 0, 0, 32'h0);

        rst_n  = 1'b0;
        done_i = '0;
        idle();
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].w, vt[i].wd, vt[i].we, vt[i].en);
            #1;
            chk($sformatf("v%0d obuf_rd_en", i), 32'(obuf_rd_en), 32'(vt[i].e_ren));
            if (vt[i].e_ren) begin
                chk($sformatf("v%0d obuf_rd_ch", i), 32'(obuf_rd_ch), 32'(vt[i].e_sel));
                chk($sformatf("v%0d obuf_rd_addr", i), 32'(obuf_rd_addr), 32'(vt[i].e_a));
            end
            if (vt[i].e_err) exp_errs++;
            step();
            idle();
            chk($sformatf("v%0d ifmap_wr_en", i), 32'(ifmap_wr_en), 32'(vt[i].e_ifm));
            chk($sformatf("v%0d w_wr_en", i), 32'(w_wr_en), 32'(vt[i].e_w));
            if (vt[i].e_ifm) begin
                chk($sformatf("v%0d ifmap_bank", i), 32'(ifmap_wr_bank), 32'(vt[i].e_sel));
                chk($sformatf("v%0d ifmap_addr", i), 32'(ifmap_wr_addr), 32'(vt[i].e_a));
                chk($sformatf("v%0d ifmap_data", i), 32'(ifmap_wr_data), 32'(vt[i].e_d));
            end
            if (vt[i].e_w) begin
                chk($sformatf("v%0d w_row", i), 32'(w_wr_row), 32'(vt[i].e_sel));
                chk($sformatf("v%0d w_addr", i), 32'(w_wr_addr), 32'(vt[i].e_a));
                chk($sformatf("v%0d w_data", i), 32'(w_wr_data), 32'(vt[i].e_d));
            end
            if (vt[i].chk_rd) chk($sformatf("v%0d rddata", i), bus.rddata_a, vt[i].e_rd);
            step();
            chk($sformatf("v%0d ifmap_wr_en_off", i), 32'(ifmap_wr_en), 32'd0);
            chk($sformatf("v%0d w_wr_en_off", i), 32'(w_wr_en), 32'd0);
            chk($sformatf("v%0d start_off", i), 32'(start_o), 32'd0);
            if (vt[i].chk_rd) chk($sformatf("v%0d rddata_hold", i), bus.rddata_a, vt[i].e_rd);
        end

        // Start pulse, layer select, sticky done and its clear.
        drive(CSR_W0, 8'h05, 4'hF, 1'b0);
        step();
        idle();
        chk("csr0 start", 32'(start_o), 32'd1);
        chk("csr0 nth", 32'(nth_conv_o), 32'd2);
        step();
        chk("csr0 start_end", 32'(start_o), 32'd0);
        chk("csr0 nth_hold", 32'(nth_conv_o), 32'd2);
        done_i = DW'(8);
        step();
        done_i = '0;
        drive(CSR_W0+1, 8'h00, 4'h0, 1'b1);
        step();
        idle();
        chk("csr1 done3", bus.rddata_a, 32'h8);
        drive(CSR_W0, 8'h01, 4'hF, 1'b0);
        step();
        idle();
        chk("start2 pulse", 32'(start_o), 32'd1);
        chk("start2 nth", 32'(nth_conv_o), 32'd0);
        step();
        drive(CSR_W0+1, 8'h00, 4'h0, 1'b1);
        step();
        idle();
        chk("csr1 cleared", bus.rddata_a, 32'h0);

        // Back-to-back starts; done arriving with the second pulse is dropped.
        drive(CSR_W0, 8'h03, 4'hF, 1'b0);
        step();
        chk("b2b pulse1", 32'(start_o), 32'd1);
        chk("b2b nth", 32'(nth_conv_o), 32'd1);
        step();
        idle();
        chk("b2b pulse2", 32'(start_o), 32'd1);
        done_i = DW'(1);
        step();
        done_i = '0;
        chk("b2b end", 32'(start_o), 32'd0);
        drive(CSR_W0+1, 8'h00, 4'h0, 1'b1);
        step();
        idle();
        chk("csr1 clear_wins", bus.rddata_a, 32'h0);
        drive(CSR_W0, 8'h06, 4'hF, 1'b0);
        step();
        idle();
        chk("csr0 nostart", 32'(start_o), 32'd0);
        chk("csr0 nth3", 32'(nth_conv_o), 32'd3);
        step();

        // Write and read in the same cycle to the obuf tag: write wins, no read.
        drive(OBUF_5_195, 8'h00, 4'h0, 1'b1);
        step();
        idle();
        chk("pre_coll rddata", bus.rddata_a, 32'h19);
        drive(OBUF_5_195, 8'h77, 4'hF, 1'b1);
        #1;
        chk("coll obuf_rd_en", 32'(obuf_rd_en), 32'd0);
        exp_errs++;
        step();
        idle();
        chk("coll rddata", bus.rddata_a, 32'h19);
        step();
        chk("coll rddata_hold", bus.rddata_a, 32'h19);

        drive(CSR_W0+2, 8'h00, 4'h0, 1'b1);
        step();
        idle();
`ifdef BRAM_ERR_CNT_EN
        chk("csr2 errcnt", bus.rddata_a, 32'(exp_errs));
`else
        chk("csr2 errcnt", bus.rddata_a, 32'h0);
`endif
        drive(CSR_W0+2, 8'hAB, 4'hF, 1'b0);
        step();
        idle();
        step();
        drive(CSR_W0+2, 8'h00, 4'h0, 1'b1);
        step();
        idle();
        chk("csr2 after_clear", bus.rddata_a, 32'h0);
        step();

        // Reset while a write strobe is on the outputs.
        drive(2<<17, 8'h00, 4'h0, 1'b1);
        step();
        idle();
        chk("prerst rddata", bus.rddata_a, 32'h42);
        step();
        drive((1<<17)+(2<<11)+9, 8'h66, 4'hF, 1'b0);
        step();
        chk("prerst strobe", 32'(ifmap_wr_en), 32'd1);
        chk("prerst bank", 32'(ifmap_wr_bank), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        step();
        idle();
        rst_n = 1'b1;
        step();
        chk("postrst ifmap_wr_en", 32'(ifmap_wr_en), 32'd0);
        chk("postrst nth", 32'(nth_conv_o), 32'd0);
        step();
        chk("postrst ifmap_wr_en2", 32'(ifmap_wr_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
